// File: rtl/tx_flow_sched_pkg.sv
// Shared types and helpers for the token-bucket flow scheduler.
// Token values carry TOKEN_FRAC_BITS fractional bits (1/256 byte units).
package tx_flow_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam int TOKEN_FRAC_BITS = 8;
    localparam int MAX_KEEP_WIDTH  = 64;
    localparam int POP_WIDTH       = 7;

    // Callers zero-extend their tkeep to MAX_KEEP_WIDTH.
    function automatic logic [POP_WIDTH-1:0] popcount(input logic [MAX_KEEP_WIDTH-1:0] keep);
        logic [POP_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_KEEP_WIDTH; i++) begin
            n = n + POP_WIDTH'(keep[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/tx_flow_bucket.sv
// Per-flow token bucket: refill capped at burst, debit applied after the cap,
// floor saturated at the most negative representable value.
module tx_flow_bucket #(
    parameter int RATE_WIDTH  = 16,
    parameter int TOKEN_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [RATE_WIDTH-1:0]         rate,
    input  logic [TOKEN_WIDTH-2:0]        burst,
    input  logic [TOKEN_WIDTH-1:0]        debit,
    input  logic                          enable,
    output logic signed [TOKEN_WIDTH-1:0] bucket,
    output logic                          positive
);

    localparam int WW = TOKEN_WIDTH + 2;

    logic signed [TOKEN_WIDTH-1:0] bucket_q, bucket_d;
    logic signed [WW-1:0]          rate_w, burst_w, debit_w, floor_w;
    logic signed [WW-1:0]          sum_w, cap_w, diff_w;

    assign rate_w  = $signed({{(WW-RATE_WIDTH){1'b0}}, rate});
    assign burst_w = $signed({3'b000, burst});
    assign debit_w = $signed({2'b00, debit});
    assign floor_w = $signed({3'b111, {(TOKEN_WIDTH-1){1'b0}}});

    // Two guard bits make the add, cap and subtract overflow-free.
    always_comb begin
        sum_w  = $signed({{2{bucket_q[TOKEN_WIDTH-1]}}, bucket_q}) + rate_w;
        cap_w  = (sum_w > burst_w) ? burst_w : sum_w;
        diff_w = cap_w - debit_w;
        if (diff_w < floor_w) begin
            bucket_d = $signed({1'b1, {(TOKEN_WIDTH-1){1'b0}}});
        end else begin
            bucket_d = $signed(TOKEN_WIDTH'(diff_w));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bucket_q <= '0;
        end else begin
            bucket_q <= bucket_d;
        end
    end

    // A disabled flow keeps refilling; enable only masks eligibility.
    assign bucket   = bucket_q;
    assign positive = enable & ~bucket_q[TOKEN_WIDTH-1];

endmodule

// File: rtl/tx_flow_sched.sv
// Frame-granular round-robin scheduler sharing one MAC TX stream between
// token-bucket shaped flows; one whole frame per grant.
module tx_flow_sched
    import tx_flow_sched_pkg::*;
#(
    parameter int N_FLOWS     = 2,
    parameter int DATA_WIDTH  = 64,
    parameter int KEEP_WIDTH  = DATA_WIDTH/8,
    parameter int RATE_WIDTH  = 16,
    parameter int TOKEN_WIDTH = 32,
    parameter int CNT_WIDTH   = 16,
    parameter int GW          = (N_FLOWS > 1) ? $clog2(N_FLOWS) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_FLOWS*DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [N_FLOWS*KEEP_WIDTH-1:0]      s_axis_tkeep,
    input  logic [N_FLOWS-1:0]                 s_axis_tvalid,
    output logic [N_FLOWS-1:0]                 s_axis_tready,
    input  logic [N_FLOWS-1:0]                 s_axis_tlast,
    output logic [DATA_WIDTH-1:0]              m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]              m_axis_tkeep,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic                               m_axis_tlast,
    output logic                               m_axis_tuser,
    input  logic [N_FLOWS-1:0]                 cfg_enable,
    input  logic [N_FLOWS*RATE_WIDTH-1:0]      cfg_rate,
    input  logic [N_FLOWS*(TOKEN_WIDTH-1)-1:0] cfg_burst,
    output logic                               stat_busy,
    output logic [GW-1:0]                      stat_grant,
    output logic [N_FLOWS*CNT_WIDTH-1:0]       stat_frames
);

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_FLOWS-1:0] eligible;
    logic [N_FLOWS-1:0] positive_w;
    logic [N_FLOWS*TOKEN_WIDTH-1:0] bucket_flat;
    logic            frame_done;
    logic            buckets_unused;

    // Bucket levels stay on named nets for debug visibility only.
    assign buckets_unused = ^bucket_flat;

    for (genvar gi = 0; gi < N_FLOWS; gi++) begin : g_flow
        logic [MAX_KEEP_WIDTH-1:0] keep_ext;
        logic [TOKEN_WIDTH-1:0]    debit_w;
        logic signed [TOKEN_WIDTH-1:0] bucket_w;
        logic [CNT_WIDTH-1:0]      frames_q;

        always_comb begin
            keep_ext = '0;
            keep_ext[KEEP_WIDTH-1:0] = s_axis_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
        end

        assign debit_w = (s_axis_tvalid[gi] & s_axis_tready[gi])
                       ? (TOKEN_WIDTH'(popcount(keep_ext)) << TOKEN_FRAC_BITS)
                       : '0;

        tx_flow_bucket #(
            .RATE_WIDTH  (RATE_WIDTH),
            .TOKEN_WIDTH (TOKEN_WIDTH)
        ) u_bucket (
            .clk      (clk),
            .rst      (rst),
            .rate     (cfg_rate[gi*RATE_WIDTH +: RATE_WIDTH]),
            .burst    (cfg_burst[gi*(TOKEN_WIDTH-1) +: (TOKEN_WIDTH-1)]),
            .debit    (debit_w),
            .enable   (cfg_enable[gi]),
            .bucket   (bucket_w),
            .positive (positive_w[gi])
        );

        assign bucket_flat[gi*TOKEN_WIDTH +: TOKEN_WIDTH] = bucket_w;
        assign eligible[gi] = s_axis_tvalid[gi] & positive_w[gi];

        always_ff @(posedge clk) begin
            if (rst) begin
                frames_q <= '0;
            end else if (frame_done && (grant_q == GW'(gi))) begin
                frames_q <= frames_q + 1'b1;
            end
        end

        assign stat_frames[gi*CNT_WIDTH +: CNT_WIDTH] = frames_q;
    end

    // Output mux is purely combinational from the registered grant.
    always_comb begin
        m_axis_tdata  = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tkeep  = s_axis_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH];
        m_axis_tlast  = s_axis_tlast[grant_q];
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        if (state_q == SEND) begin
            m_axis_tvalid          = s_axis_tvalid[grant_q];
            s_axis_tready[grant_q] = m_axis_tready;
        end
    end

    assign frame_done = (state_q == SEND) & m_axis_tvalid & m_axis_tready & m_axis_tlast;

    always_comb begin
        logic found;
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        found    = 1'b0;
        case (state_q)
            IDLE: begin
                for (int k = 1; k <= N_FLOWS; k++) begin
                    int idx;
                    idx = int'(rr_ptr_q) + k;
                    if (idx >= N_FLOWS) begin
                        idx = idx - N_FLOWS;
                    end
                    if (!found && eligible[idx]) begin
                        found   = 1'b1;
                        grant_d = GW'(idx);
                    end
                end
                if (found) begin
                    state_d  = SEND;
                    rr_ptr_d = grant_d;
                end
            end
            SEND: begin
                if (frame_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= GW'(N_FLOWS-1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign stat_busy    = (state_q == SEND);
    assign stat_grant   = grant_q;
    assign m_axis_tuser = 1'b0;

endmodule

// File: tb/tb_tx_flow_sched.sv
// Directed bench for tx_flow_sched: cycle table for round-robin/backpressure,
// plus sequences for token debt, random stalls, disable and reset mid-frame.
module tb_tx_flow_sched;

    localparam int NF = 2;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int RW = 16;
    localparam int TW = 32;
    localparam int CW = 16;

    logic                   clk;
    logic                   rst;
    logic [NF*DW-1:0]       s_axis_tdata;
    logic [NF*KW-1:0]       s_axis_tkeep;
    logic [NF-1:0]          s_axis_tvalid;
    logic [NF-1:0]          s_axis_tready;
    logic [NF-1:0]          s_axis_tlast;
    logic [DW-1:0]          m_axis_tdata;
    logic [KW-1:0]          m_axis_tkeep;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready;
    logic                   m_axis_tlast;
    logic                   m_axis_tuser;
    logic [NF-1:0]          cfg_enable;
    logic [NF*RW-1:0]       cfg_rate;
    logic [NF*(TW-1)-1:0]   cfg_burst;
    logic                   stat_busy;
    logic [0:0]             stat_grant;
    logic [NF*CW-1:0]       stat_frames;

    tx_flow_sched #(
        .N_FLOWS(NF), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
        .RATE_WIDTH(RW), .TOKEN_WIDTH(TW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .cfg_enable(cfg_enable), .cfg_rate(cfg_rate), .cfg_burst(cfg_burst),
        .stat_busy(stat_busy), .stat_grant(stat_grant), .stat_frames(stat_frames)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Flow generators: tdata = {flow id, per-flow beat sequence number}.
    int  seq [NF];
    int  idx [NF];
    int  len [NF];
    bit  gen_on [NF];
    bit  gap [NF];
    bit  vld [NF];
    bit  mrand;
    int  tests, fails, cyc;

    bit             c_mv, c_ml, c_busy, c_mtr;
    logic [0:0]     c_grant;
    logic [DW-1:0]  c_md;
    logic [NF-1:0]  c_str, c_acc, c_sv;
    logic [CW-1:0]  c_frames [NF];

    task automatic drive();
        for (int f = 0; f < NF; f++) begin
            s_axis_tvalid[f]         = gen_on[f] & vld[f];
            s_axis_tdata[f*DW +: DW] = {32'(f), 32'(seq[f])};
            s_axis_tlast[f]          = (idx[f] == len[f] - 1);
            s_axis_tkeep[f*KW +: KW] = '1;
        end
    endtask

    task automatic tick();
        if (mrand) m_axis_tready = 1'($urandom_range(0, 1));
        drive();
        @(negedge clk);
        c_mv = m_axis_tvalid; c_ml = m_axis_tlast; c_md = m_axis_tdata;
        c_busy = stat_busy; c_grant = stat_grant; c_str = s_axis_tready;
        c_sv = s_axis_tvalid; c_mtr = m_axis_tready;
        c_acc = s_axis_tvalid & s_axis_tready;
        for (int f = 0; f < NF; f++) c_frames[f] = stat_frames[f*CW +: CW];
        @(posedge clk);
        #1;
        cyc++;
        for (int f = 0; f < NF; f++) begin
            if (c_acc[f]) begin
                seq[f]++;
                idx[f] = (idx[f] == len[f] - 1) ? 0 : idx[f] + 1;
            end
            vld[f] = gap[f] ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        drive();
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        tests++;
        if (val < lo || val > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, val, lo, hi, cyc);
        end
    endtask

    task automatic gen_reset();
        for (int f = 0; f < NF; f++) begin
            seq[f] = 0; idx[f] = 0; vld[f] = 1'b1;
        end
        drive();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        gen_reset();
        rst = 1'b0;
    endtask

    typedef struct {
        bit         mtr;
        bit         ev;
        bit         el;
        bit         eb;
        bit         eg;
        logic [63:0] ed;
        bit [1:0]   etr;
    } vec_t;

    function automatic vec_t mk(bit mtr, bit ev, bit el, bit eb, bit eg, int df, int ds, bit [1:0] etr);
        vec_t v;
        v.mtr = mtr; v.ev = ev; v.el = el; v.eb = eb; v.eg = eg;
        v.ed = {32'(df), 32'(ds)}; v.etr = etr;
        return v;
    endfunction

    vec_t tbl [19];

    initial begin
        int  nf0, f1cnt, last_f0, exp_seq, f0_new;
        bit  prev, done, f0_done;

        tests = 0; fails = 0; cyc = 0;
        rst = 1'b1; mrand = 1'b0; m_axis_tready = 1'b1;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = '0; s_axis_tlast = '0;
        for (int f = 0; f < NF; f++) begin
            len[f] = 3; gen_on[f] = 1'b1; gap[f] = 1'b0;
        end
        gen_reset();
        cfg_enable = 2'b11;
        cfg_rate   = {16'h0800, 16'h0800};
        cfg_burst  = {31'h10000, 31'h10000};

        // Reset state
        do_reset(3);
        check("rst_tvalid", c_mv, 0);
        check("rst_busy", c_busy, 0);
        check("rst_tready", c_str, 0);
        check("rst_grant", c_grant, 0);
        check("rst_frames0", c_frames[0], 0);
        check("rst_frames1", c_frames[1], 0);

        // Two flows, 3-beat frames, alternating grants with stalls in flow 1's first frame
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 2'b00);
        tbl[1]  = mk(1, 1, 0, 1, 0, 0, 0, 2'b01);
        tbl[2]  = mk(1, 1, 0, 1, 0, 0, 1, 2'b01);
        tbl[3]  = mk(1, 1, 1, 1, 0, 0, 2, 2'b01);
        tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0, 2'b00);
        tbl[5]  = mk(0, 1, 0, 1, 1, 1, 0, 2'b00);
        tbl[6]  = mk(1, 1, 0, 1, 1, 1, 0, 2'b10);
        tbl[7]  = mk(1, 1, 0, 1, 1, 1, 1, 2'b10);
        tbl[8]  = mk(0, 1, 1, 1, 1, 1, 2, 2'b00);
        tbl[9]  = mk(1, 1, 1, 1, 1, 1, 2, 2'b10);
        tbl[10] = mk(1, 0, 0, 0, 1, 0, 0, 2'b00);
        tbl[11] = mk(1, 1, 0, 1, 0, 0, 3, 2'b01);
        tbl[12] = mk(1, 1, 0, 1, 0, 0, 4, 2'b01);
        tbl[13] = mk(1, 1, 1, 1, 0, 0, 5, 2'b01);
        tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, 2'b00);
        tbl[15] = mk(1, 1, 0, 1, 1, 1, 3, 2'b10);
        tbl[16] = mk(1, 1, 0, 1, 1, 1, 4, 2'b10);
        tbl[17] = mk(1, 1, 1, 1, 1, 1, 5, 2'b10);
        tbl[18] = mk(1, 0, 0, 0, 1, 0, 0, 2'b00);
        for (int i = 0; i < 19; i++) begin
            m_axis_tready = tbl[i].mtr;
            tick();
            check($sformatf("rr_valid[%0d]", i), c_mv, tbl[i].ev);
            check($sformatf("rr_busy[%0d]", i), c_busy, tbl[i].eb);
            check($sformatf("rr_grant[%0d]", i), c_grant, tbl[i].eg);
            check($sformatf("rr_sready[%0d]", i), c_str, tbl[i].etr);
            if (tbl[i].ev) begin
                check($sformatf("rr_data[%0d]", i), c_md, tbl[i].ed);
                check($sformatf("rr_last[%0d]", i), c_ml, tbl[i].el);
            end
        end
        check("rr_frames0", c_frames[0], 2);
        check("rr_frames1", c_frames[1], 2);

        // Token debt: flow 0 at 1 B/cycle with 64 B frames, flow 1 fills the gaps
        m_axis_tready = 1'b1;
        cfg_rate  = {16'h0800, 16'h0100};
        cfg_burst = {31'h10000, 31'h04000};
        len[0] = 8; len[1] = 3;
        do_reset(2);
        prev = 1'b0; nf0 = 0; f1cnt = 0; last_f0 = 0;
        for (int i = 0; i < 300 && nf0 < 3; i++) begin
            tick();
            if (c_busy && !prev) begin
                if (c_grant == 1'b0) begin
                    if (nf0 == 0) check("debt_first_start", i, 1);
                    else begin
                        check_range("debt_gap", i - last_f0, 60, 70);
                        check_range("debt_f1_between", f1cnt, 12, 20);
                    end
                    nf0++; last_f0 = i; f1cnt = 0;
                end else begin
                    f1cnt++;
                end
            end
            prev = c_busy;
        end
        check("debt_starts", nf0, 3);

        // Random backpressure and tvalid gaps during one 10-beat frame of flow 0
        cfg_enable = 2'b01;
        cfg_rate   = {16'h0800, 16'h0800};
        cfg_burst  = {31'h10000, 31'h10000};
        len[0] = 10; len[1] = 3; gap[0] = 1'b1; mrand = 1'b1;
        do_reset(2);
        exp_seq = 0; done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            if (c_busy) begin
                check("bp_grant", c_grant, 0);
                check("bp_other_ready", c_str[1], 0);
                check("bp_ready_track", c_str[0], c_mtr);
                check("bp_valid_track", c_mv, c_sv[0]);
                if (c_mv) begin
                    check("bp_data", c_md, {32'd0, 32'(exp_seq)});
                    check("bp_last", c_ml, exp_seq == 9);
                    if (c_mtr) begin
                        if (exp_seq == 9) done = 1'b1;
                        exp_seq++;
                    end
                end
            end
        end
        check("bp_done", done, 1);
        mrand = 1'b0; gap[0] = 1'b0; m_axis_tready = 1'b1;
        tick();
        check("bp_frames0", c_frames[0], 1);

        // Disable flow 0 mid-frame
        cfg_enable = 2'b11;
        len[0] = 6; len[1] = 6;
        do_reset(2);
        repeat (3) tick();
        cfg_enable = 2'b10;
        prev = 1'b1; f0_new = 0; f0_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (c_busy && !prev && c_grant == 1'b0) f0_new++;
            if (c_busy && c_mv && c_mtr && c_ml && c_grant == 1'b0) f0_done = 1'b1;
            prev = c_busy;
        end
        check("dis_tlast_seen", f0_done, 1);
        check("dis_no_regrant", f0_new, 0);
        check("dis_frames0", c_frames[0], 1);
        check("dis_frames1", c_frames[1], 5);

        // Reset in the middle of a flow 1 frame
        cfg_enable = 2'b11;
        repeat (2) tick();
        check("mid_busy_pre", c_busy, 1);
        check("mid_grant_pre", c_grant, 1);
        rst = 1'b1;
        tick();
        tick();
        check("mid_rst_tvalid", c_mv, 0);
        check("mid_rst_busy", c_busy, 0);
        check("mid_rst_frames0", c_frames[0], 0);
        check("mid_rst_frames1", c_frames[1], 0);
        gen_reset();
        rst = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            tick();
            if (c_busy) begin
                done = 1'b1;
                check("mid_first_start", i, 1);
                check("mid_first_grant", c_grant, 0);
            end
        end
        check("mid_regrant", done, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
